rv32_data_memory: RTL

//   Parametrised byte-addressable data memory for the RV32IM pipeline MEM stage.

---
 rtl/rv32_data_memory.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rv32_data_memory.sv
// Byte-addressable little-endian data memory for the RV32 MEM stage.
// A fixed-latency busywait handshake is used, and misaligned or illegal accesses are flagged.
//
//   state | meaning
//   IDLE  | waiting for exactly one of read/write; busywait follows read^write
//   BUSY  | request latched, latency down-counter running; commit at terminal count
//   DONE  | one-cycle result window: readdata/access_fault valid, busywait low
module rv32_data_memory #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        access_fault
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state, state_next;
  logic [3:0]              counter;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              funct3_q;
  logic [31:0]             wdata_q;
  logic                    store_q;
  logic [7:0]              mem [DEPTH];

  logic                    accept;
  logic                    commit;
  logic                    fault;
  logic [31:0]             load_value;
  logic [2:0]              store_bytes;
  logic [7:0]              b0, b1, b2, b3;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^address[31:ADDR_WIDTH];

  assign accept = (state == IDLE) && (read ^ write);
  assign commit = (state == BUSY) && (counter == 4'd0);

  always_comb begin
    state_next = state;
    busywait   = 1'b0;
    case (state)
      IDLE: begin
        busywait = read ^ write;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        busywait = 1'b1;
        if (counter == 4'd0) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Misalignment and illegal size/sign encodings share one fault flag.
  always_comb begin
    fault = 1'b0;
    case (funct3_q)
      3'b000:  fault = 1'b0;
      3'b001:  fault = addr_q[0];
      3'b010:  fault = (addr_q[1:0] != 2'b00);
      3'b100:  fault = store_q;
      3'b101:  fault = store_q | addr_q[0];
      default: fault = 1'b1;
    endcase
  end

  // Byte indices wrap naturally in ADDR_WIDTH-bit arithmetic.
  always_comb begin
    b0 = mem[addr_q];
    b1 = mem[addr_q + ADDR_WIDTH'(1)];
    b2 = mem[addr_q + ADDR_WIDTH'(2)];
    b3 = mem[addr_q + ADDR_WIDTH'(3)];
    load_value = 32'd0;
    case (funct3_q)
      3'b000:  load_value = {{24{b0[7]}}, b0};
      3'b001:  load_value = {{16{b1[7]}}, b1, b0};
      3'b010:  load_value = {b3, b2, b1, b0};
      3'b100:  load_value = {24'd0, b0};
      3'b101:  load_value = {16'd0, b1, b0};
      default: load_value = 32'd0;
    endcase
  end

  always_comb begin
    store_bytes = 3'd0;
    case (funct3_q)
      3'b000:  store_bytes = 3'd1;
      3'b001:  store_bytes = 3'd2;
      3'b010:  store_bytes = 3'd4;
      default: store_bytes = 3'd0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= 4'd0;
      addr_q       <= '0;
      funct3_q     <= 3'd0;
      wdata_q      <= 32'd0;
      store_q      <= 1'b0;
      readdata     <= 32'd0;
      access_fault <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= address[ADDR_WIDTH-1:0];
        funct3_q <= funct3;
        wdata_q  <= writedata;
        store_q  <= write;
        counter  <= CNT_INIT;
      end else if (state == BUSY && counter != 4'd0) begin
        counter <= counter - 4'd1;
      end
      if (commit) begin
        access_fault <= fault;
        if (!store_q) readdata <= fault ? 32'd0 : load_value;
      end else if (state == DONE) begin
        access_fault <= 1'b0;
      end
    end
  end

  // Contents survive reset; a reset before the commit edge leaves state IDLE, so no write.
  always_ff @(posedge clock) begin
    if (commit && store_q && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < store_bytes) mem[addr_q + ADDR_WIDTH'(k)] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule
